// File: rtl/bht_update_ctrl_if.sv
// Fetch/resolve/SRAM signal bundle for bht_update_ctrl.
// slave = controller side, master = surrounding fetch/resolve/SRAM side.
interface bht_update_ctrl_if #(
    parameter int IDXW = 6
);
    logic            lookupValid;
    logic [IDXW-1:0] lookupIdx;
    logic            lookupGrant;
    logic            predValid;
    logic            predTaken;
    logic            resolveValid;
    logic [IDXW-1:0] resolveIdx;
    logic            resolveTaken;
    logic            resolveReady;
    logic            tblEn;
    logic            tblWe;
    logic [IDXW-1:0] tblIdx;
    logic [1:0]      tblWdata;
    logic [1:0]      tblRdata;
    logic            initBusy;

    modport slave (
        input  lookupValid, lookupIdx, resolveValid, resolveIdx, resolveTaken, tblRdata,
        output lookupGrant, predValid, predTaken, resolveReady,
        output tblEn, tblWe, tblIdx, tblWdata, initBusy
    );

    modport master (
        output lookupValid, lookupIdx, resolveValid, resolveIdx, resolveTaken, tblRdata,
        input  lookupGrant, predValid, predTaken, resolveReady,
        input  tblEn, tblWe, tblIdx, tblWdata, initBusy
    );
endinterface

// File: rtl/bht_update_ctrl.sv
// BHT controller: arbitrates lookups against FIFO-buffered read-modify-write counter updates.
// Define BHT_INIT_SWEEP_EN to sweep every entry to weakly-not-taken (2'b01) after reset.
module bht_update_ctrl #(
    parameter int ENTRIES = 64,
    parameter int QDEPTH  = 4,
    parameter int IDXW    = $clog2(ENTRIES)
) (
    input logic              clk,
    input logic              reset,
    bht_update_ctrl_if.slave bus
);
    localparam int PTRW = $clog2(QDEPTH);
    localparam int CNTW = PTRW + 1;

`ifdef BHT_INIT_SWEEP_EN
    typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_UPD_WR = 2'd2} state_t;
    localparam state_t RST_STATE = ST_INIT;
    logic [IDXW-1:0] init_cnt_q, init_cnt_d;
`else
    typedef enum logic [1:0] {ST_RUN = 2'd1, ST_UPD_WR = 2'd2} state_t;
    localparam state_t RST_STATE = ST_RUN;
`endif

    state_t          state_q, state_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDXW-1:0] fifo_idx_q [QDEPTH];
    logic [IDXW-1:0] fifo_idx_d [QDEPTH];
    logic            fifo_tkn_q [QDEPTH];
    logic            fifo_tkn_d [QDEPTH];
    logic            pred_valid_q, pred_valid_d;

    logic            fifo_full_s, fifo_empty_s, enq_s, pop_s, grant_s, ready_s;
    logic            tbl_en_s, tbl_we_s;
    logic [IDXW-1:0] tbl_idx_s, head_idx_s;
    logic [1:0]      tbl_wdata_s;
    logic            head_tkn_s;

    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b11;
            3'b1_10: nxt = 2'b11;
            3'b1_11: nxt = 2'b11;
            3'b0_11: nxt = 2'b10;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    assign fifo_full_s  = (count_q == CNTW'(QDEPTH));
    assign fifo_empty_s = (count_q == {CNTW{1'b0}});
    assign head_idx_s   = fifo_idx_q[rd_ptr_q];
    assign head_tkn_s   = fifo_tkn_q[rd_ptr_q];

    // Arbitration FSM: next state and SRAM command; everything held quiet while reset is high.
    always_comb begin
        state_d     = state_q;
        grant_s     = 1'b0;
        ready_s     = 1'b0;
        pop_s       = 1'b0;
        tbl_en_s    = 1'b0;
        tbl_we_s    = 1'b0;
        tbl_idx_s   = {IDXW{1'b0}};
        tbl_wdata_s = 2'b00;
`ifdef BHT_INIT_SWEEP_EN
        init_cnt_d  = init_cnt_q;
`endif
        if (reset) begin
            state_d = RST_STATE;
        end else begin
            case (state_q)
`ifdef BHT_INIT_SWEEP_EN
                ST_INIT: begin
                    tbl_en_s    = 1'b1;
                    tbl_we_s    = 1'b1;
                    tbl_idx_s   = init_cnt_q;
                    tbl_wdata_s = 2'b01;
                    init_cnt_d  = init_cnt_q + 1'b1;
                    if (init_cnt_q == IDXW'(ENTRIES - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
`endif
                ST_RUN: begin
                    ready_s = !fifo_full_s;
                    // A full FIFO outranks lookups so updates cannot starve.
                    if (fifo_full_s) begin
                        tbl_en_s  = 1'b1;
                        tbl_idx_s = head_idx_s;
                        state_d   = ST_UPD_WR;
                    end else if (bus.lookupValid) begin
                        grant_s   = 1'b1;
                        tbl_en_s  = 1'b1;
                        tbl_idx_s = bus.lookupIdx;
                    end else if (!fifo_empty_s) begin
                        tbl_en_s  = 1'b1;
                        tbl_idx_s = head_idx_s;
                        state_d   = ST_UPD_WR;
                    end else begin
                        tbl_en_s  = 1'b0;
                    end
                end
                ST_UPD_WR: begin
                    ready_s     = !fifo_full_s;
                    tbl_en_s    = 1'b1;
                    tbl_we_s    = 1'b1;
                    tbl_idx_s   = head_idx_s;
                    tbl_wdata_s = next_ctr(bus.tblRdata, head_tkn_s);
                    pop_s       = 1'b1;
                    state_d     = ST_RUN;
                end
                default: begin
                    state_d = RST_STATE;
                end
            endcase
        end
    end

    assign enq_s = bus.resolveValid && ready_s;

    // Update FIFO bookkeeping; readiness is from the registered count, so a pop never frees a same-cycle slot.
    always_comb begin
        fifo_idx_d = fifo_idx_q;
        fifo_tkn_d = fifo_tkn_q;
        if (enq_s) begin
            fifo_idx_d[wr_ptr_q] = bus.resolveIdx;
            fifo_tkn_d[wr_ptr_q] = bus.resolveTaken;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d             = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d      = count_q + CNTW'(enq_s) - CNTW'(pop_s);
        pred_valid_d = grant_s;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RST_STATE;
            count_q      <= {CNTW{1'b0}};
            rd_ptr_q     <= {PTRW{1'b0}};
            wr_ptr_q     <= {PTRW{1'b0}};
            pred_valid_q <= 1'b0;
`ifdef BHT_INIT_SWEEP_EN
            init_cnt_q   <= {IDXW{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pred_valid_q <= pred_valid_d;
`ifdef BHT_INIT_SWEEP_EN
            init_cnt_q   <= init_cnt_d;
`endif
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        fifo_idx_q <= fifo_idx_d;
        fifo_tkn_q <= fifo_tkn_d;
    end

    assign bus.lookupGrant  = grant_s;
    assign bus.resolveReady = ready_s;
    assign bus.tblEn        = tbl_en_s;
    assign bus.tblWe        = tbl_we_s;
    assign bus.tblIdx       = tbl_idx_s;
    assign bus.tblWdata     = tbl_wdata_s;
    assign bus.predValid    = pred_valid_q;
    // The SRAM output register supplies the counter the cycle after the grant.
    assign bus.predTaken    = pred_valid_q & bus.tblRdata[1];
`ifdef BHT_INIT_SWEEP_EN
    assign bus.initBusy     = (state_q == ST_INIT);
`else
    assign bus.initBusy     = 1'b0;
`endif
endmodule
